// File: rtl/sig_unsig_entry.sv
// sig_unsig_entry: keyed decimal entry (up to NDIG digits plus sign) converted
// to a WIDTH-bit two's complement or unsigned word with an overflow flag.
// Raw buttons are synchronised and edge-detected into single-cycle pulses
// that drive a three-state entry FSM.
module sig_unsig_entry #(
   parameter int WIDTH = 4,
   parameter int NDIG  = 2
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [3:0]       digit,
   input  logic             enter_btn,
   input  logic             neg_btn,
   input  logic             done_btn,
   input  logic             clr_btn,
   input  logic             interp,
   output logic [WIDTH-1:0] x,
   output logic             ovf,
   output logic             valid,
   output logic [1:0]       dig_cnt,
   output logic             neg
);

   // Magnitude register must hold 10**NDIG - 1.
   localparam int MAG_W = $clog2(10 ** NDIG);
   // Comparison width wide enough for both the magnitude and 2**WIDTH - 1.
   localparam int CW    = ((MAG_W > WIDTH) ? MAG_W : WIDTH) + 1;

   localparam logic [CW-1:0] SPOS_LIM = CW'(2 ** (WIDTH - 1) - 1);
   localparam logic [CW-1:0] SNEG_LIM = CW'(2 ** (WIDTH - 1));
   localparam logic [CW-1:0] UMAX_LIM = CW'(2 ** WIDTH - 1);

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ENTRY = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   // Button vector order: {clr, done, enter, neg}.
   logic [3:0] btn_raw_s;
   logic [3:0] sync1_q, sync2_q, sync3_q, pulse_q;

   state_t             state_q;
   logic [MAG_W-1:0]   mag_q;
   logic [1:0]         dig_cnt_q;
   logic               neg_q;
   logic [WIDTH-1:0]   x_q;
   logic               ovf_q;
   logic               valid_q;

   logic               act_clr_s, act_done_s, act_enter_s, act_neg_s;
   logic               digit_ok_s;
   logic [MAG_W-1:0]   mag_next_s;
   logic [CW-1:0]      mag_ext_s;
   logic [WIDTH-1:0]   mag_w_s;
   logic [WIDTH-1:0]   x_d;
   logic               ovf_d;

   assign btn_raw_s = {clr_btn, done_btn, enter_btn, neg_btn};

   // Two-flop synchroniser, edge detector and registered one-cycle pulse.
   // Flops reset to 1 so a button held through reset never looks like a rise.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 4'b1111;
         sync2_q <= 4'b1111;
         sync3_q <= 4'b1111;
         pulse_q <= 4'b0000;
      end else begin
         sync1_q <= btn_raw_s;
         sync2_q <= sync1_q;
         sync3_q <= sync2_q;
         pulse_q <= sync2_q & ~sync3_q;
      end
   end

   // Resolve coincident pulses: clr beats done beats enter beats neg.
   always_comb begin
      act_clr_s   = pulse_q[3];
      act_done_s  = pulse_q[2] & ~pulse_q[3];
      act_enter_s = pulse_q[1] & ~pulse_q[2] & ~pulse_q[3];
      act_neg_s   = pulse_q[0] & ~pulse_q[1] & ~pulse_q[2] & ~pulse_q[3];
      digit_ok_s  = (digit <= 4'd9);
      mag_next_s  = mag_q * MAG_W'(4'd10) + MAG_W'(digit);
   end

   // Commit value and overflow for the current magnitude, sign and mode.
   always_comb begin
      mag_ext_s = CW'(mag_q);
      mag_w_s   = WIDTH'(mag_q);
      x_d       = {WIDTH{1'b0}};
      ovf_d     = 1'b0;
      if (interp) begin
         if (neg_q) begin
            ovf_d = (mag_ext_s > SNEG_LIM);
            x_d   = ~mag_w_s + {{(WIDTH-1){1'b0}}, 1'b1};
         end else begin
            ovf_d = (mag_ext_s > SPOS_LIM);
            x_d   = mag_w_s;
         end
      end else begin
         ovf_d = (neg_q & (mag_q != {MAG_W{1'b0}})) | (mag_ext_s > UMAX_LIM);
         x_d   = mag_w_s;
      end
   end

   // Entry FSM with registered outputs; clr from any state keeps the last commit.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= ST_EMPTY;
         mag_q     <= {MAG_W{1'b0}};
         dig_cnt_q <= 2'd0;
         neg_q     <= 1'b0;
         x_q       <= {WIDTH{1'b0}};
         ovf_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else if (act_clr_s) begin
         state_q   <= ST_EMPTY;
         mag_q     <= {MAG_W{1'b0}};
         dig_cnt_q <= 2'd0;
         neg_q     <= 1'b0;
         valid_q   <= 1'b0;
      end else begin
         case (state_q)
            ST_EMPTY: begin
               if (act_enter_s && digit_ok_s) begin
                  mag_q     <= MAG_W'(digit);
                  dig_cnt_q <= 2'd1;
                  state_q   <= ST_ENTRY;
               end else if (act_neg_s) begin
                  neg_q <= ~neg_q;
               end else begin
                  state_q <= ST_EMPTY;
               end
            end
            ST_ENTRY: begin
               if (act_done_s) begin
                  x_q     <= x_d;
                  ovf_q   <= ovf_d;
                  valid_q <= 1'b1;
                  state_q <= ST_DONE;
               end else if (act_enter_s && digit_ok_s && (dig_cnt_q < 2'(NDIG))) begin
                  mag_q     <= mag_next_s;
                  dig_cnt_q <= dig_cnt_q + 2'd1;
               end else if (act_neg_s) begin
                  neg_q <= ~neg_q;
               end else begin
                  state_q <= ST_ENTRY;
               end
            end
            ST_DONE: begin
               if (act_enter_s && digit_ok_s) begin
                  mag_q     <= MAG_W'(digit);
                  dig_cnt_q <= 2'd1;
                  neg_q     <= 1'b0;
                  valid_q   <= 1'b0;
                  state_q   <= ST_ENTRY;
               end else if (act_neg_s) begin
                  neg_q     <= 1'b1;
                  mag_q     <= {MAG_W{1'b0}};
                  dig_cnt_q <= 2'd0;
                  valid_q   <= 1'b0;
                  state_q   <= ST_EMPTY;
               end else begin
                  state_q <= ST_DONE;
               end
            end
            default: begin
               state_q   <= ST_EMPTY;
               mag_q     <= {MAG_W{1'b0}};
               dig_cnt_q <= 2'd0;
               neg_q     <= 1'b0;
               valid_q   <= 1'b0;
            end
         endcase
      end
   end

   assign x       = x_q;
   assign ovf     = ovf_q;
   assign valid   = valid_q;
   assign dig_cnt = dig_cnt_q;
   assign neg     = neg_q;

endmodule

// File: tb/tb_sig_unsig_entry.sv
// Directed bench for sig_unsig_entry: each scenario task drives buttons and
// compares outputs against hand-computed values.
module tb_sig_unsig_entry;

   logic       clk;
   logic       reset_n;
   logic [3:0] digit;
   logic       enter_btn, neg_btn, done_btn, clr_btn;
   logic       interp;
   logic [3:0] x;
   logic       ovf, valid, neg;
   logic [1:0] dig_cnt;

   int checks;
   int errors;

   sig_unsig_entry #(.WIDTH(4), .NDIG(2)) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .digit     (digit),
      .enter_btn (enter_btn),
      .neg_btn   (neg_btn),
      .done_btn  (done_btn),
      .clr_btn   (clr_btn),
      .interp    (interp),
      .x         (x),
      .ovf       (ovf),
      .valid     (valid),
      .dig_cnt   (dig_cnt),
      .neg       (neg)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // which = {clr, done, enter, neg}; held 4 cycles then released 4 cycles.
   task automatic press(input logic [3:0] which);
      @(negedge clk);
      {clr_btn, done_btn, enter_btn, neg_btn} = which;
      repeat (4) @(negedge clk);
      {clr_btn, done_btn, enter_btn, neg_btn} = 4'b0000;
      repeat (4) @(negedge clk);
   endtask

   task automatic key(input logic [3:0] d);
      digit = d;
      press(4'b0010);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      {clr_btn, done_btn, enter_btn, neg_btn} = 4'b0000;
      digit = 4'd0;
      interp = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (x !== 4'b0000) begin errors++; $display("FAIL reset_x got %b exp %b", x, 4'b0000); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf got %b exp 0", ovf); end
      checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", valid); end
      checks++; if (dig_cnt !== 2'd0) begin errors++; $display("FAIL reset_dig_cnt got %0d exp 0", dig_cnt); end
      checks++; if (neg !== 1'b0) begin errors++; $display("FAIL reset_neg got %b exp 0", neg); end
      reset_n = 1'b1;
      repeat (4) @(negedge clk);
   endtask

   task automatic test_signed_neg3();
      press(4'b1000);
      interp = 1'b1;
      press(4'b0001);
      checks++; if (neg !== 1'b1) begin errors++; $display("FAIL neg3_sign got %b exp 1", neg); end
      key(4'd3);
      checks++; if (dig_cnt !== 2'd1) begin errors++; $display("FAIL neg3_dig_cnt got %0d exp 1", dig_cnt); end
      press(4'b0100);
      checks++; if (x !== 4'b1101) begin errors++; $display("FAIL neg3_x got %b exp %b", x, 4'b1101); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL neg3_ovf got %b exp 0", ovf); end
      checks++; if (valid !== 1'b1) begin errors++; $display("FAIL neg3_valid got %b exp 1", valid); end
      checks++; if (neg !== 1'b1) begin errors++; $display("FAIL neg3_neg got %b exp 1", neg); end
   endtask

   task automatic test_twelve();
      press(4'b1000);
      interp = 1'b1;
      key(4'd1); key(4'd2);
      checks++; if (dig_cnt !== 2'd2) begin errors++; $display("FAIL twelve_dig_cnt got %0d exp 2", dig_cnt); end
      press(4'b0100);
      checks++; if (x !== 4'b1100) begin errors++; $display("FAIL twelve_s_x got %b exp %b", x, 4'b1100); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL twelve_s_ovf got %b exp 1", ovf); end
      interp = 1'b0;
      repeat (4) @(negedge clk);
      checks++; if (ovf !== 1'b1 || x !== 4'b1100) begin errors++; $display("FAIL twelve_hold got x=%b ovf=%b exp x=1100 ovf=1", x, ovf); end
      press(4'b1000);
      key(4'd1); key(4'd2);
      press(4'b0100);
      checks++; if (x !== 4'b1100) begin errors++; $display("FAIL twelve_u_x got %b exp %b", x, 4'b1100); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL twelve_u_ovf got %b exp 0", ovf); end
   endtask

   task automatic test_minus8();
      press(4'b1000);
      interp = 1'b1;
      press(4'b0001); key(4'd8); press(4'b0100);
      checks++; if (x !== 4'b1000) begin errors++; $display("FAIL m8_s_x got %b exp %b", x, 4'b1000); end
      checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL m8_s_ovf got %b exp 0", ovf); end
      press(4'b1000);
      interp = 1'b0;
      press(4'b0001); key(4'd8); press(4'b0100);
      checks++; if (x !== 4'b1000) begin errors++; $display("FAIL m8_u_x got %b exp %b", x, 4'b1000); end
      checks++; if (ovf !== 1'b1) begin errors++; $display("FAIL m8_u_ovf got %b exp 1", ovf); end
      // -9 signed overflows; -0 commits clean
      press(4'b1000);
      interp = 1'b1;
      press(4'b0001); key(4'd9); press(4'b0100);
      checks++; if (ovf !== 1'b1 || x !== 4'b0111) begin errors++; $display("FAIL m9_s got x=%b ovf=%b exp x=0111 ovf=1", x, ovf); end
      press(4'b1000);
      press(4'b0001); key(4'd0); press(4'b0100);
      checks++; if (x !== 4'b0000 || ovf !== 1'b0 || valid !== 1'b1) begin errors++; $display("FAIL m0_s got x=%b ovf=%b valid=%b exp 0000/0/1", x, ovf, valid); end
      // DONE then neg: back to EMPTY with sign set
      press(4'b0001);
      checks++; if (valid !== 1'b0 || neg !== 1'b1 || dig_cnt !== 2'd0) begin errors++; $display("FAIL done_neg got valid=%b neg=%b dig=%0d exp 0/1/0", valid, neg, dig_cnt); end
   endtask

   task automatic test_digit_limit();
      press(4'b1000);
      interp = 1'b0;
      key(4'd1); key(4'd2); key(4'd5);
      checks++; if (dig_cnt !== 2'd2) begin errors++; $display("FAIL limit_dig_cnt got %0d exp 2", dig_cnt); end
      press(4'b0100);
      checks++; if (x !== 4'b1100 || ovf !== 1'b0) begin errors++; $display("FAIL limit_x got x=%b ovf=%b exp 1100/0", x, ovf); end
      press(4'b1000);
      key(4'hA);
      checks++; if (dig_cnt !== 2'd0 || valid !== 1'b0) begin errors++; $display("FAIL illegal_digit got dig=%0d valid=%b exp 0/0", dig_cnt, valid); end
      checks++; if (x !== 4'b1100) begin errors++; $display("FAIL clr_keeps_x got %b exp %b", x, 4'b1100); end
   endtask

   task automatic test_clr_done();
      press(4'b1000);
      interp = 1'b1;
      key(4'd7);
      press(4'b1100);
      checks++; if (valid !== 1'b0 || dig_cnt !== 2'd0) begin errors++; $display("FAIL clr_done got valid=%b dig=%0d exp 0/0", valid, dig_cnt); end
      checks++; if (x !== 4'b1100) begin errors++; $display("FAIL clr_done_x got %b exp %b", x, 4'b1100); end
      key(4'd5); press(4'b0001);
      checks++; if (dig_cnt !== 2'd1 || neg !== 1'b1) begin errors++; $display("FAIL pre_reset got dig=%0d neg=%b exp 1/1", dig_cnt, neg); end
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      checks++; if (x !== 4'b0000 || ovf !== 1'b0 || valid !== 1'b0 || dig_cnt !== 2'd0 || neg !== 1'b0) begin
         errors++; $display("FAIL async_reset got x=%b ovf=%b valid=%b dig=%0d neg=%b exp all 0", x, ovf, valid, dig_cnt, neg);
      end
      repeat (2) @(negedge clk);
      reset_n = 1'b1;
      repeat (6) @(negedge clk);
      checks++; if (dig_cnt !== 2'd0 || valid !== 1'b0) begin errors++; $display("FAIL post_reset got dig=%0d valid=%b exp 0/0", dig_cnt, valid); end
   endtask

   task automatic test_held_reset_and_latency();
      @(negedge clk);
      reset_n = 1'b0;
      digit = 4'd4;
      enter_btn = 1'b1;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (8) @(negedge clk);
      checks++; if (dig_cnt !== 2'd0) begin errors++; $display("FAIL held_reset got dig=%0d exp 0", dig_cnt); end
      enter_btn = 1'b0;
      repeat (5) @(negedge clk);
      enter_btn = 1'b1;
      repeat (3) @(negedge clk);
      checks++; if (dig_cnt !== 2'd0) begin errors++; $display("FAIL latency_early got dig=%0d exp 0", dig_cnt); end
      @(negedge clk);
      checks++; if (dig_cnt !== 2'd1) begin errors++; $display("FAIL latency_edge got dig=%0d exp 1", dig_cnt); end
      repeat (8) @(negedge clk);
      checks++; if (dig_cnt !== 2'd1) begin errors++; $display("FAIL single_pulse got dig=%0d exp 1", dig_cnt); end
      enter_btn = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin
      checks = 0;
      errors = 0;
      test_reset();
      test_signed_neg3();
      test_twelve();
      test_minus8();
      test_digit_limit();
      test_clr_done();
      test_held_reset_and_latency();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
